seq_det_sched: RTL and testbench

//  Round-robin scheduler sharing one serial pattern detector (default 10011) among NREQ bit-stream requesters.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_match_core.sv | 54 +++++
 rtl/seq_det_sched.sv | 189 ++++++++++++++++++
 tb/tb_seq_det_sched.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the round-robin pattern-detector scheduler.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    STREAM = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int DEF_PAT_W = 5;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 5'b10011;

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: history shift register, fill count and window compare.
// hit is combinational so the owner can count the completing bit in the same cycle.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int              PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_in,
  input  logic bit_en,
  output logic hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-2:0]  hist_r;
  logic [FILL_W-1:0] fill_r;
  logic [PAT_W-1:0]  window_s;
  logic [FILL_W-1:0] fill_nx_s;
  logic              full_s;

  // Window including the incoming bit, and saturating fill increment
  always_comb begin
    window_s = {hist_r, bit_in};
    full_s   = (fill_r >= FILL_W'(PAT_W - 1));
    hit      = bit_en & full_s & (window_s == PATTERN);
    if (fill_r == FILL_W'(PAT_W)) begin
      fill_nx_s = fill_r;
    end else begin
      fill_nx_s = fill_r + 1'b1;
    end
  end

  // History update; after a match only the completing bit seeds the next window
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (clr) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (bit_en) begin
      hist_r <= window_s[PAT_W-2:0];
      fill_r <= hit ? FILL_W'(1) : fill_nx_s;
    end else begin
      hist_r <= hist_r;
      fill_r <= fill_r;
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler that lends one serial pattern detector to NREQ lanes,
// one frame at a time, and reports the per-frame hit count with the lane id.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int               NREQ    = 4,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               LEN_W   = 8,
  parameter int               CNT_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           x,
  input  logic [NREQ-1:0]           x_valid,
  input  logic [LEN_W-1:0]          frame_len,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic                      z,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      aborted
);

  localparam int IDW = $clog2(NREQ);
  localparam int SW  = IDW + 1;

  state_t           state_r, state_nx_s;
  logic [IDW-1:0]   cur_r, cur_nx_s, ptr_r, pick_s, lane_s;
  logic [SW-1:0]    sum_s;
  logic             pick_ok_s;
  logic [LEN_W-1:0] len_r, bit_cnt_r, bit_cnt_nx_s;
  logic [CNT_W-1:0] hit_cnt_r, hit_nx_s;
  logic             accept_s, hit_s, abort_s;

  logic [NREQ-1:0]  gnt_r;
  logic             busy_r, z_r, done_r, aborted_r;
  logic [IDW-1:0]   done_id_r;
  logic [CNT_W-1:0] match_cnt_r;

  seq_match_core #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (state_r == GRANT),
    .bit_in(x[cur_r]),
    .bit_en(accept_s),
    .hit   (hit_s)
  );

  // Round-robin search: first requesting lane at or after ptr, wrapping
  always_comb begin
    pick_ok_s = 1'b0;
    pick_s    = '0;
    sum_s     = '0;
    lane_s    = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_s     = {1'b0, ptr_r} + SW'(i);
      lane_s    = (sum_s >= SW'(NREQ)) ? IDW'(sum_s - SW'(NREQ)) : sum_s[IDW-1:0];
      pick_s    = (!pick_ok_s && req[lane_s]) ? lane_s : pick_s;
      pick_ok_s = pick_ok_s | req[lane_s];
    end
  end

  // Per-bit datapath: acceptance, length count and saturating hit count
  always_comb begin
    accept_s     = (state_r == STREAM) & req[cur_r] & x_valid[cur_r];
    bit_cnt_nx_s = bit_cnt_r + 1'b1;
    if (hit_s && (hit_cnt_r != '1)) begin
      hit_nx_s = hit_cnt_r + 1'b1;
    end else begin
      hit_nx_s = hit_cnt_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    cur_nx_s   = cur_r;
    abort_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_ok_s) begin
          state_nx_s = GRANT;
          cur_nx_s   = pick_s;
        end else begin
          state_nx_s = IDLE;
        end
      end
      GRANT: begin
        if (frame_len == '0) begin
          state_nx_s = REPORT;
        end else begin
          state_nx_s = STREAM;
        end
      end
      STREAM: begin
        if (!req[cur_r]) begin
          state_nx_s = REPORT;
          abort_s    = 1'b1;
        end else if (accept_s && (bit_cnt_nx_s == len_r)) begin
          state_nx_s = REPORT;
        end else begin
          state_nx_s = STREAM;
        end
      end
      REPORT:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Control state: FSM, current lane, RR pointer, frame counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      cur_r     <= '0;
      ptr_r     <= '0;
      len_r     <= '0;
      bit_cnt_r <= '0;
      hit_cnt_r <= '0;
    end else begin
      state_r <= state_nx_s;
      cur_r   <= cur_nx_s;
      case (state_r)
        GRANT: begin
          len_r     <= frame_len;
          bit_cnt_r <= '0;
          hit_cnt_r <= '0;
        end
        STREAM: begin
          if (accept_s) begin
            bit_cnt_r <= bit_cnt_nx_s;
            hit_cnt_r <= hit_nx_s;
          end else begin
            bit_cnt_r <= bit_cnt_r;
            hit_cnt_r <= hit_cnt_r;
          end
        end
        REPORT: begin
          ptr_r <= (cur_r == IDW'(NREQ - 1)) ? '0 : cur_r + 1'b1;
        end
        default: begin
          ptr_r <= ptr_r;
        end
      endcase
    end
  end

  // Outputs registered from the next state so they line up with the state
  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_r       <= '0;
      busy_r      <= 1'b0;
      z_r         <= 1'b0;
      done_r      <= 1'b0;
      done_id_r   <= '0;
      match_cnt_r <= '0;
      aborted_r   <= 1'b0;
    end else begin
      gnt_r  <= ((state_nx_s == GRANT) || (state_nx_s == STREAM)) ?
                ({{(NREQ-1){1'b0}}, 1'b1} << cur_nx_s) : '0;
      busy_r <= (state_nx_s != IDLE);
      z_r    <= hit_s;
      done_r <= (state_nx_s == REPORT);
      if (state_nx_s == REPORT) begin
        done_id_r   <= cur_nx_s;
        match_cnt_r <= (state_r == STREAM) ? hit_nx_s : '0;
        aborted_r   <= abort_s;
      end else begin
        done_id_r   <= done_id_r;
        match_cnt_r <= match_cnt_r;
        aborted_r   <= aborted_r;
      end
    end
  end

  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign z         = z_r;
  assign done      = done_r;
  assign done_id   = done_id_r;
  assign match_cnt = match_cnt_r;
  assign aborted   = aborted_r;

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed self-checking bench for seq_det_sched (default build plus a CNT_W=2 build).
module tb_seq_det_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, x, x_valid;
  logic [7:0] frame_len;
  logic [3:0] gnt, gnt2, match_cnt;
  logic       busy, busy2, z, z2, done, done2, aborted, aborted2;
  logic [1:0] done_id, done_id2, match_cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_det_sched #(.NREQ(4), .PAT_W(5), .PATTERN(5'b10011), .LEN_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .x(x), .x_valid(x_valid), .frame_len(frame_len),
    .gnt(gnt), .busy(busy), .z(z), .done(done), .done_id(done_id),
    .match_cnt(match_cnt), .aborted(aborted));

  seq_det_sched #(.NREQ(4), .PAT_W(5), .PATTERN(5'b10011), .LEN_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .req(req), .x(x), .x_valid(x_valid), .frame_len(frame_len),
    .gnt(gnt2), .busy(busy2), .z(z2), .done(done2), .done_id(done_id2),
    .match_cnt(match_cnt2), .aborted(aborted2));

  // Passive monitor sampled on the falling edge
  int         cyc = 0;
  int         z_cnt = 0, z2_cnt = 0, z_cyc = 0, gnt_hi = 0, onehot_bad = 0;
  int         grant_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic [3:0] grant_val = 4'd0, prev_gnt = 4'd0, match_m = 4'd0;
  logic [1:0] done_id_m = 2'd0, match2_m = 2'd0;
  logic       abort_m = 1'b0;
  bit         have_done = 1'b0;
  int         done_q[$];
  int         gap_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (z) begin z_cnt++; z_cyc = cyc; end
    if (z2) z2_cnt++;
    if (gnt != 4'd0) begin
      gnt_hi++;
      if ($countones(gnt) != 1) onehot_bad++;
    end
    if (gnt != 4'd0 && prev_gnt == 4'd0) begin
      grant_cyc = cyc;
      grant_val = gnt;
      if (have_done) gap_q.push_back(cyc - done_cyc);
    end
    if (done) begin
      done_cyc  = cyc;
      done_cnt++;
      done_id_m = done_id;
      match_m   = match_cnt;
      match2_m  = match_cnt2;
      abort_m   = aborted;
      have_done = 1'b1;
      done_q.push_back(int'(done_id));
    end
    prev_gnt = gnt;
  end

  task automatic clear_mon();
    z_cnt = 0; z2_cnt = 0; gnt_hi = 0; onehot_bad = 0; done_cnt = 0;
    have_done = 1'b0;
    done_q.delete();
    gap_q.delete();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Stream one frame on a lane; other lanes carry inverted, valid noise
  task automatic drive_frame(input int lane, input int len, input logic [127:0] bits,
                             input int nbits, input bit toggle, input int drop_after,
                             output bit ok);
    int  k = 0;
    int  j = -1;
    bit  got = 1'b0;
    bit  vld;
    logic bitv;
    ok = 1'b0;
    x = 4'd0; x_valid = 4'd0;
    frame_len = 8'(len);
    req[lane] = 1'b1;
    for (int w = 0; w < 20 && !got; w++) begin
      @(posedge clk); #1;
      if (gnt[lane]) got = 1'b1;
    end
    if (got) begin
      for (int c = 0; c < 400 && !ok; c++) begin
        if (drop_after >= 0 && k >= drop_after) req[lane] = 1'b0;
        bitv = (k < nbits) ? bits[nbits-1-k] : 1'b0;
        vld  = (j >= 0) && (!toggle || (j % 2 == 0));
        x          = {4{~bitv}};
        x[lane]    = bitv;
        x_valid    = 4'b1111;
        x_valid[lane] = vld;
        @(posedge clk); #1;
        if (vld && req[lane]) k++;
        j++;
        if (done) ok = 1'b1;
      end
    end
    req[lane] = 1'b0; x = 4'd0; x_valid = 4'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'd0; x = 4'd0; x_valid = 4'd0; frame_len = 8'd0;
    @(posedge clk); #1;
    tests++;
    if ({gnt, busy, z, done, done_id, match_cnt, aborted} !== 14'd0) begin
      fails++;
      $display("FAIL reset_outputs got gnt=%b busy=%b z=%b done=%b id=%0d cnt=%0d ab=%b exp all 0",
               gnt, busy, z, done, done_id, match_cnt, aborted);
    end
    tests++;
    if ({gnt2, busy2, z2, done2, done_id2, match_cnt2, aborted2} !== 12'd0) begin
      fails++;
      $display("FAIL reset_outputs_cnt2 got %b exp 0",
               {gnt2, busy2, z2, done2, done_id2, match_cnt2, aborted2});
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    clear_mon();
    drive_frame(0, 5, 128'b10011, 5, 1'b0, -1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL t1_timeout got no done exp done"); end
    tests++;
    if (grant_val !== 4'b0001) begin fails++; $display("FAIL t1_gnt got %b exp 0001", grant_val); end
    tests++;
    if (gnt_hi != 6) begin fails++; $display("FAIL t1_gnt_cycles got %0d exp 6", gnt_hi); end
    tests++;
    if (z_cnt != 1 || z_cyc != done_cyc) begin
      fails++; $display("FAIL t1_z got cnt=%0d at %0d exp 1 at %0d", z_cnt, z_cyc, done_cyc);
    end
    tests++;
    if (done_cyc - grant_cyc != 6) begin
      fails++; $display("FAIL t1_latency got %0d exp 6", done_cyc - grant_cyc);
    end
    tests++;
    if ({done_id_m, match_m, abort_m} !== {2'd0, 4'd1, 1'b0}) begin
      fails++; $display("FAIL t1_report got id=%0d cnt=%0d ab=%b exp 0 1 0", done_id_m, match_m, abort_m);
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    pulse_reset();
    clear_mon();
    frame_len = 8'd3; x = 4'd0; x_valid = 4'b1111; req = 4'b1111;
    for (int c = 0; c < 200 && n < 5; c++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    req = 4'd0; x_valid = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (done_q.size() != 5) begin
      fails++; $display("FAIL t2_done_count got %0d exp 5", done_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (done_q[i] != (i % 4)) begin
          fails++; $display("FAIL t2_done_id[%0d] got %0d exp %0d", i, done_q[i], i % 4);
        end
      end
    end
    tests++;
    if (onehot_bad != 0) begin fails++; $display("FAIL t2_onehot got %0d bad exp 0", onehot_bad); end
    tests++;
    if (gap_q.size() != 4) begin
      fails++; $display("FAIL t2_gap_count got %0d exp 4", gap_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (gap_q[i] != 2) begin fails++; $display("FAIL t2_gap[%0d] got %0d exp 2", i, gap_q[i]); end
      end
    end
  endtask

  task automatic test_nonoverlap();
    bit ok;
    clear_mon();
    drive_frame(3, 9, 128'b100110011, 9, 1'b0, -1, ok);
    tests++;
    if (!ok || match_m !== 4'd2 || z_cnt != 2 || done_id_m !== 2'd3) begin
      fails++; $display("FAIL t3_two_hits got ok=%0d cnt=%0d z=%0d id=%0d exp 1 2 2 3",
                        ok, match_m, z_cnt, done_id_m);
    end
    clear_mon();
    drive_frame(3, 8, 128'b10011011, 8, 1'b0, -1, ok);
    tests++;
    if (!ok || match_m !== 4'd1 || z_cnt != 1) begin
      fails++; $display("FAIL t3_one_hit got ok=%0d cnt=%0d z=%0d exp 1 1 1", ok, match_m, z_cnt);
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_mon();
    drive_frame(2, 10, 128'b1001100110, 10, 1'b1, -1, ok);
    tests++;
    if (!ok || done_cyc - grant_cyc != 20) begin
      fails++; $display("FAIL t4_stall_latency got ok=%0d %0d exp 20", ok, done_cyc - grant_cyc);
    end
    tests++;
    if (match_m !== 4'd2 || done_id_m !== 2'd2) begin
      fails++; $display("FAIL t4_stall_cnt got cnt=%0d id=%0d exp 2 2", match_m, done_id_m);
    end
    clear_mon();
    drive_frame(2, 10, 128'b1001100110, 10, 1'b0, -1, ok);
    tests++;
    if (!ok || done_cyc - grant_cyc != 11 || match_m !== 4'd2) begin
      fails++; $display("FAIL t4_b2b got ok=%0d lat=%0d cnt=%0d exp 1 11 2",
                        ok, done_cyc - grant_cyc, match_m);
    end
  endtask

  task automatic test_abort_zero();
    bit ok;
    clear_mon();
    drive_frame(1, 10, 128'b10011, 5, 1'b0, 3, ok);
    tests++;
    if (!ok || done_cyc - grant_cyc != 5) begin
      fails++; $display("FAIL t5_abort_latency got ok=%0d %0d exp 5", ok, done_cyc - grant_cyc);
    end
    tests++;
    if ({done_id_m, match_m, abort_m} !== {2'd1, 4'd0, 1'b1}) begin
      fails++; $display("FAIL t5_abort got id=%0d cnt=%0d ab=%b exp 1 0 1", done_id_m, match_m, abort_m);
    end
    clear_mon();
    drive_frame(1, 0, 128'b0, 0, 1'b0, -1, ok);
    tests++;
    if (!ok || done_cyc - grant_cyc != 1 || match_m !== 4'd0 || abort_m !== 1'b0) begin
      fails++; $display("FAIL t5_len0 got ok=%0d lat=%0d cnt=%0d ab=%b exp 1 1 0 0",
                        ok, done_cyc - grant_cyc, match_m, abort_m);
    end
  endtask

  task automatic test_saturate_reset();
    bit ok;
    bit got;
    logic [127:0] b;
    b = 128'd0;
    for (int i = 0; i < 20; i++) b = {b[122:0], 5'b10011};
    clear_mon();
    drive_frame(1, 100, b, 100, 1'b0, -1, ok);
    tests++;
    if (!ok || match2_m !== 2'd3 || z2_cnt != 20) begin
      fails++; $display("FAIL t6_sat_cnt2 got ok=%0d cnt=%0d z=%0d exp 1 3 20", ok, match2_m, z2_cnt);
    end
    tests++;
    if (match_m !== 4'd15 || z_cnt != 20 || done_cyc - grant_cyc != 101) begin
      fails++; $display("FAIL t6_sat_cnt4 got cnt=%0d z=%0d lat=%0d exp 15 20 101",
                        match_m, z_cnt, done_cyc - grant_cyc);
    end
    frame_len = 8'd10; x = 4'd0; x_valid = 4'b1111; req = 4'b0100;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(posedge clk); #1;
      if (gnt[2]) got = 1'b1;
    end
    for (int w = 0; w < 3; w++) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (!got || gnt !== 4'd0 || done !== 1'b0 || busy !== 1'b0 || match_cnt !== 4'd0) begin
      fails++; $display("FAIL t6_mid_reset got granted=%0d gnt=%b done=%b busy=%b cnt=%0d exp 1 0000 0 0 0",
                        got, gnt, done, busy, match_cnt);
    end
    reset = 1'b1;
    req = 4'b0101;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(posedge clk); #1;
      if (gnt != 4'd0) got = 1'b1;
    end
    tests++;
    if (gnt !== 4'b0001) begin fails++; $display("FAIL t6_grant_after_reset got %b exp 0001", gnt); end
    req = 4'd0; x_valid = 4'd0;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(posedge clk); #1;
      if (!busy) got = 1'b1;
    end
    tests++;
    if (!got) begin fails++; $display("FAIL t6_idle_timeout got busy=%b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_nonoverlap();
    test_stall();
    test_abort_zero();
    test_saturate_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
